hilo_mdu: RTL
=============

# hilo_mdu

Multi-cycle multiply/divide unit with the architectural HI/LO registers. It sits beside the combinational ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode, computes iteratively while the core stalls on `busy_o`, and holds HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  operation request; sampled only when the unit is idle.
- `op_i`  in  3  `mdu_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a_i`  in  32  rs value; dividend, multiplicand, or MTHI/MTLO source.
- `b_i`  in  32  rt value; divisor or multiplier.
- `busy_o`  out  1  iterative operation in progress; core must stall MDU ops and MFHI/MFLO.
- `done_o`  out  1  one-cycle pulse in the first cycle that new HI/LO values are visible.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.

## Operation
- Reset: state IDLE, `hi_o`=`lo_o`=0, `busy_o`=0, `done_o`=0, and the iteration counter is 0. Reset mid-operation aborts the operation with no partial HI/LO write.
- FSM states:
  - IDLE: on `start_i`, latch operands and decode op.
    - MTHI/MTLO: write HI or LO with `a_i`, stay in IDLE.
    - MULT*: go to MUL.
    - DIV*: go to DIV.
  - MUL: shift-add, one multiplier bit per cycle, 32 cycles. Then go to FIX.
  - DIV: restoring division, one quotient bit per cycle, 32 cycles. Then go to FIX.
  - FIX: apply signs, write HI/LO, go to IDLE.
- Signed ops work on magnitudes.
  - MULT: product negated if the operand signs differ. Result is 64-bit; HI = [63:32], LO = [31:0].
  - DIV: quotient truncates toward zero (negated if signs differ). Remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU with `b_i`=0): HI = `a_i` unmodified, LO = 0xFFFFFFFF. Latency is unchanged and sign fix is bypassed.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start_i` while `busy_o`=1 is ignored: no queueing and no effect on the current op.
- HI/LO change only in FIX, on an MTHI/MTLO, or on reset.

## Timing
- Edge E0 samples `start_i`.
- Iterative ops:
  - `busy_o` is high from the cycle after E0 through the cycle before `done_o`.
  - HI/LO update on edge E34 (1 load, 32 iterations, 1 fix).
  - `done_o` is high for the cycle following E34, and `busy_o` is low in that cycle.
  - A new `start_i` is accepted in the `done_o` cycle.
- MTHI/MTLO: register updates on E0, `done_o` is high the next cycle, and `busy_o` never rises.
- Back-to-back MTHI/MTLO can be accepted on consecutive cycles.
- `done_o` is registered, never combinational from `start_i`.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU compute with a single-cycle 64-bit multiply.
  - HI/LO are written on E0 and `done_o` is high the next cycle.
  - `busy_o` never asserts for multiplies; the MUL state is unused.
- Undefined: the 34-cycle shift-add path above. Divide is iterative in both builds.

## Structure
- Package `mdu_pkg`:
  - `mdu_op_t` enum with a 3-bit encoding.
  - `mdu_state_t` enum (IDLE, MUL, DIV, FIX).
  - Constants `MDU_ITERS`=32 and `MDU_DIV0_LO`=32'hFFFFFFFF.
- Sub-module `mdu_divider`: iterative restoring unsigned core with start, done, quotient and remainder. `hilo_mdu` keeps the FSM, sign handling, multiply path and HI/LO.

## Test plan
- Reset asserted mid-DIV at cycle 10 → `hi_o`=`lo_o`=0, `busy_o`=0 immediately. A new DIVU 7/2 after release → LO=3, HI=1 at E34.
- MULT 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU of the same operands → HI=0x00000002, LO=0xFFFFFFFA. Latency 34 (1 with `MDU_FAST_MULT_EN`).
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 and DIV 0xFFFFFFF0 / 0 → HI = dividend, LO=0xFFFFFFFF, `done_o` at E34.
- MTHI 0xDEADBEEF then MTLO 0xCAFEF00D on consecutive cycles → both visible, two `done_o` pulses, `busy_o`=0 throughout.
- MTLO 5 issued with `start_i` during a running DIVU 100/7 → ignored. Final LO=14, HI=2. A `start_i` in the `done_o` cycle is accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, constants and helpers for the HI/LO multiply/divide unit
package mdu_pkg;

  localparam int          MDU_ITERS   = 32;
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  // Absolute value for signed ops; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - decode-side request and HI/LO result bundle of the multiply/divide unit
interface hilo_mdu_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             start_i;
  mdu_op_t          op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (output start_i, op_i, a_i, b_i, input busy_o, done_o, hi_o, lo_o);
  modport slave  (input start_i, op_i, a_i, b_i, output busy_o, done_o, hi_o, lo_o);

endinterface

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative restoring unsigned divider, one quotient bit per cycle
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] LAST = 5'(MDU_ITERS - 1);

  logic        run_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [31:0] rem_next;
  logic        fits;

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    fits     = (shifted >= {1'b0, dvs_q});
    rem_next = shifted[31:0] - dvs_q;
  end

  // Load on start, then retire one quotient bit per cycle and pulse done after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run_q <= 1'b1;
        cnt_q <= '0;
        quo_q <= dividend;
        rem_q <= '0;
        dvs_q <= divisor;
      end else if (run_q) begin
        quo_q <= {quo_q[30:0], fits};
        rem_q <= fits ? rem_next : shifted[31:0];
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO multiply/divide unit; MDU_FAST_MULT_EN selects a single-cycle multiply
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  hilo_mdu_if.slave bus
);

  localparam logic [5:0] ITERS = 6'(MDU_ITERS);

  mdu_state_t       state_q, state_d;
  logic [5:0]       cnt_q;
  logic             accept, op_signed, op_mul, op_div;
  logic [WIDTH-1:0] hi_q, lo_q, a_q;
  logic             neg_res_q, neg_rem_q, div0_q, done_q;
  logic [31:0]      a_mag, b_mag;
  logic             div_done;
  logic [31:0]      quo, rem;

  // Decode the request; only meaningful when it is accepted in IDLE.
  always_comb begin
    op_mul    = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
    op_div    = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
    op_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  end

  assign accept = (state_q == IDLE) && bus.start_i;
  assign a_mag  = magnitude(bus.a_i, op_signed);
  assign b_mag  = magnitude(bus.b_i, op_signed);

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_prod;
  assign fast_prod = {{32{op_signed & bus.a_i[31]}}, bus.a_i} *
                     {{32{op_signed & bus.b_i[31]}}, bus.b_i};
`else
  logic [63:0] prod_q;
  logic [31:0] mcand_q;
  logic [32:0] partial;
  logic [63:0] mul_res;
  logic        is_div_q;

  assign partial = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_res = neg_res_q ? -prod_q : prod_q;

  // Shift-add multiplier: multiplier magnitude sits in the low half and drains one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
    end else if (accept && op_mul) begin
      prod_q  <= {32'd0, b_mag};
      mcand_q <= a_mag;
    end else if (state_q == MUL && cnt_q != ITERS) begin
      prod_q  <= {partial, prod_q[31:1]};
    end
  end
`endif

  mdu_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && op_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // Iteration counter: cleared when an op is accepted, counts up to ITERS while iterating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == MUL || state_q == DIV) && cnt_q != ITERS) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  // Capture the raw dividend and the sign/zero facts needed by the fix-up step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`ifndef MDU_FAST_MULT_EN
      is_div_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_q       <= bus.a_i;
      neg_res_q <= op_signed & (bus.a_i[31] ^ bus.b_i[31]);
      neg_rem_q <= op_signed & bus.a_i[31];
      div0_q    <= (bus.b_i == '0);
`ifndef MDU_FAST_MULT_EN
      is_div_q  <= op_div;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: MTHI/MTLO (and fast multiplies) complete without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && op_div) state_d = DIV;
`ifndef MDU_FAST_MULT_EN
        else if (accept && op_mul) state_d = MUL;
`endif
      end
      MUL:     if (cnt_q == ITERS) state_d = FIX;
      DIV:     if (div_done) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // HI/LO writes and the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && bus.op_i == OP_MTHI) begin
        hi_q   <= bus.a_i;
        done_q <= 1'b1;
      end else if (accept && bus.op_i == OP_MTLO) begin
        lo_q   <= bus.a_i;
        done_q <= 1'b1;
`ifdef MDU_FAST_MULT_EN
      end else if (accept && op_mul) begin
        {hi_q, lo_q} <= fast_prod;
        done_q       <= 1'b1;
`endif
      end else if (state_q == FIX) begin
        done_q <= 1'b1;
`ifndef MDU_FAST_MULT_EN
        if (!is_div_q) begin
          hi_q <= mul_res[63:32];
          lo_q <= mul_res[31:0];
        end else
`endif
        if (div0_q) begin
          hi_q <= a_q;
          lo_q <= MDU_DIV0_LO;
        end else begin
          hi_q <= neg_rem_q ? -rem : rem;
          lo_q <= neg_res_q ? -quo : quo;
        end
      end
    end
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule
